alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Registered, handshaked ALU-control decode stage. It is the parametrised successor to the combinational aluOp/funct7/funct3 decoder.
- Adds full RV32I R/I-type decode and an illegal-op flag.
- Adds optional RV32M ops, which hold a busy window of configurable latency.
- Sits between the main control unit (ID) and the ALU/muldiv unit (EX).

Parameters:
- CTRL_W, 4, width of ctrl code; must be >=4; codes zero-extended.
- MUL_LAT, 3, cycles the ALU needs for mul/mulh (>=1).
- DIV_LAT, 8, cycles for div/rem (>=1).
- CNT_W, 4, busy-counter width; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode request valid
- in_ready  out  1  stage can accept
- aluOp  in  2  00 load/store add, 01 branch sub, 10 R-type, 11 I-type
- Funct7  in  7  instr[31:25]
- Funct3  in  3  instr[14:12]
- out_valid  out  1  out_ctrl valid for EX
- out_ready  in  1  EX consumes result
- out_ctrl  out  CTRL_W  ALU control code
- out_illegal  out  1  unsupported encoding
- out_busy  out  1  multi-cycle op in flight

Behaviour:
- Encoding:
  - AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SLT=0111, SLTU=1000, SRA=1001.
  - MUL=1010, MULH=1011, DIV=1100, REM=1101.
  - ILLEGAL=1111.
- aluOp 00 -> ADD; aluOp 01 -> SUB. Funct7/Funct3 are ignored for both.
- aluOp 10, Funct7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- aluOp 10, Funct7=0100000: f3 000 SUB, 101 SRA; other f3 -> ILLEGAL.
- aluOp 10, Funct7=0000001: f3 000 MUL, 001 MULH, 100 DIV, 110 REM; others -> ILLEGAL. Gated by the optional feature.
- aluOp 10, any other Funct7 -> ILLEGAL.
- aluOp 11, Funct7 ignored except for shifts: f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - f3 001: SLL if Funct7=0000000, else ILLEGAL.
  - f3 101: SRL if Funct7=0000000, SRA if Funct7=0100000, else ILLEGAL.
- out_illegal = 1 exactly when out_ctrl = ILLEGAL.
- FSM states: IDLE, HOLD, BUSY.
  - Accept happens when in_valid && in_ready; inputs are sampled on that edge.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Accepting a single-cycle or illegal op: next cycle out_valid=1, out_ctrl/out_illegal registered, state HOLD. Latency is 1.
  - Accepting MUL/MULH: state BUSY, cnt=MUL_LAT-1, out_ctrl registered, out_busy=1, out_valid=0.
  - Accepting DIV/REM: same as MUL/MULH, with cnt=DIV_LAT-1.
  - BUSY, cnt!=0: cnt decrements.
  - BUSY, cnt==0: next cycle out_valid=1, out_busy=0, state HOLD. Total accept-to-valid latency is LAT+... = exactly LAT cycles after the first busy cycle; with LAT=1, out_valid is asserted in the cycle after BUSY.
  - HOLD with out_ready=0: out_ctrl, out_valid and out_illegal are held stable.
  - HOLD with out_ready=1 and no new accept: out_valid drops, state IDLE.
  - HOLD with out_ready=1 and a simultaneous accept: back-to-back transfer, no bubble. New values replace the old; the state follows the new op's class.
  - out_ctrl is stable throughout BUSY, so the ALU can use it as its op select.
- Reset, synchronous, overrides everything, including mid-BUSY: state IDLE, cnt=0, out_valid=0, out_busy=0, out_illegal=0, out_ctrl=0010 (ADD). A request in flight during reset is dropped.
- in_valid is ignored while in_ready=0, with no side effects.

Optional Feature:
- Macro: ALU_MEXT_EN.
- Defined: the Funct7=0000001 ops decode to MUL/MULH/DIV/REM and use the BUSY path.
- Undefined: every Funct7=0000001 encoding decodes to ILLEGAL with single-cycle latency; BUSY is unreachable and out_busy is tied 0.

Test Plan:
- rst=1 for 2 cycles -> out_valid=0, out_busy=0, out_ctrl=0010, in_ready=1.
- aluOp=10, F7=0000000, F3=000, out_ready=1 -> one cycle later out_ctrl=0010, out_valid=1; then aluOp=10, F7=0100000, F3=000 back-to-back -> out_ctrl=0110 the next cycle, no bubble.
- aluOp=11, F3=101, F7=0100000 -> 1001; F7=0000000 -> 0101; F7=0000001 -> 1111 with out_illegal=1. aluOp=00 -> 0010; aluOp=01 -> 0110.
- Defaults, ALU_MEXT_EN defined, aluOp=10, F7=0000001, F3=100 -> out_busy=1 and out_ctrl=1100 for 8 cycles, in_ready=0, then out_valid=1. A MUL instead gives a 3-cycle busy window.
- out_ready=0 held 5 cycles after a valid AND result -> out_ctrl=0000 and out_valid=1 stay stable, in_ready=0, and a new in_valid is not accepted.
- rst asserted in the middle of a DIV busy window -> next cycle state IDLE, out_busy=0, out_valid=0. Build without ALU_MEXT_EN: the same DIV gives 1111 in 1 cycle.

Source files
------------

// File: rtl/alu_control_seq_if.sv
// Handshake bundle between the ID control unit, the ALU-control decode stage and EX.
// master = ID/EX environment side, slave = decode stage.
interface alu_control_seq_if #(
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        aluOp;
    logic [6:0]        Funct7;
    logic [2:0]        Funct3;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_illegal;
    logic              out_busy;

    modport master (
        output in_valid, aluOp, Funct7, Funct3, out_ready,
        input  in_ready, out_valid, out_ctrl, out_illegal, out_busy
    );

    modport slave (
        input  in_valid, aluOp, Funct7, Funct3, out_ready,
        output in_ready, out_valid, out_ctrl, out_illegal, out_busy
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered, handshaked RV32I ALU-control decode stage with an optional RV32M busy window.
// Optional feature macro: ALU_MEXT_EN (defined: MUL/MULH/DIV/REM decode and hold BUSY).
//
// state | meaning
// IDLE  | no result held, ready for a request
// HOLD  | result valid on out_ctrl, waiting for EX to consume
// BUSY  | multi-cycle op in flight, cnt counts down to terminal zero
module alu_control_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input logic             clk,
    input logic             rst,
    alu_control_seq_if.slave bus
);
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1010;
    localparam logic [3:0] C_MULH = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100;
    localparam logic [3:0] C_REM  = 4'b1101;
    localparam logic [3:0] C_ILL  = 4'b1111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
    typedef enum logic [1:0] {K_SINGLE, K_MUL, K_DIV} kind_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [CTRL_W-1:0] ctrl_q, ctrl_nx;
    logic              ill_q, ill_nx;
    logic [3:0]        dec_code;
    kind_t             dec_kind;
    logic              accept;

    always_comb begin
        dec_code = C_ILL;
        dec_kind = K_SINGLE;
        unique case (bus.aluOp)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b10: begin
                if (bus.Funct7 == F7_BASE) begin
                    case (bus.Funct3)
                        3'b000: dec_code = C_ADD;
                        3'b001: dec_code = C_SLL;
                        3'b010: dec_code = C_SLT;
                        3'b011: dec_code = C_SLTU;
                        3'b100: dec_code = C_XOR;
                        3'b101: dec_code = C_SRL;
                        3'b110: dec_code = C_OR;
                        3'b111: dec_code = C_AND;
                    endcase
                end else if (bus.Funct7 == F7_ALT) begin
                    if (bus.Funct3 == 3'b000)      dec_code = C_SUB;
                    else if (bus.Funct3 == 3'b101) dec_code = C_SRA;
                end else if (bus.Funct7 == F7_MEXT) begin
`ifdef ALU_MEXT_EN
                    case (bus.Funct3)
                        3'b000: begin dec_code = C_MUL;  dec_kind = K_MUL; end
                        3'b001: begin dec_code = C_MULH; dec_kind = K_MUL; end
                        3'b100: begin dec_code = C_DIV;  dec_kind = K_DIV; end
                        3'b110: begin dec_code = C_REM;  dec_kind = K_DIV; end
                        default: dec_code = C_ILL;
                    endcase
`else
                    dec_code = C_ILL;
`endif
                end
            end
            2'b11: begin
                case (bus.Funct3)
                    3'b000: dec_code = C_ADD;
                    3'b001: dec_code = (bus.Funct7 == F7_BASE) ? C_SLL : C_ILL;
                    3'b010: dec_code = C_SLT;
                    3'b011: dec_code = C_SLTU;
                    3'b100: dec_code = C_XOR;
                    3'b101: dec_code = (bus.Funct7 == F7_BASE) ? C_SRL :
                                       (bus.Funct7 == F7_ALT)  ? C_SRA : C_ILL;
                    3'b110: dec_code = C_OR;
                    3'b111: dec_code = C_AND;
                endcase
            end
        endcase
    end

    assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ctrl_nx  = ctrl_q;
        ill_nx   = ill_q;
        if (accept) begin
            // out_ctrl is loaded at accept so it stays stable for the whole busy window
            ctrl_nx = CTRL_W'(dec_code);
            ill_nx  = (dec_code == C_ILL);
            unique case (dec_kind)
                K_MUL: begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_W'(MUL_LAT - 1);
                end
                K_DIV: begin
                    state_nx = BUSY;
                    cnt_nx   = CNT_W'(DIV_LAT - 1);
                end
                default: state_nx = HOLD;
            endcase
        end else begin
            unique case (state)
                HOLD: if (bus.out_ready) state_nx = IDLE;
                BUSY: begin
                    if (cnt == '0) state_nx = HOLD;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ctrl_q <= CTRL_W'(C_ADD);
            ill_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ctrl_q <= ctrl_nx;
            ill_q  <= ill_nx;
        end
    end

    assign bus.out_valid   = (state == HOLD);
    assign bus.out_ctrl    = ctrl_q;
    assign bus.out_illegal = ill_q;
`ifdef ALU_MEXT_EN
    assign bus.out_busy    = (state == BUSY);
`else
    assign bus.out_busy    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed steps plus randomized transactions
// checked against a table-driven RV32I/M decode model.
module tb_alu_control_seq;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_control_seq_if #(.CTRL_W(4)) bus ();

    alu_control_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RV32I base op for each funct3 when funct7 selects the plain variant
    logic [3:0] base_tab [8] = '{4'h2, 4'h4, 4'h7, 4'h8, 4'h3, 4'h5, 4'h1, 4'h0};

    function automatic logic [3:0] ref_code(input logic [1:0] op, input logic [6:0] f7,
                                            input logic [2:0] f3);
        bit mext;
`ifdef ALU_MEXT_EN
        mext = 1'b1;
`else
        mext = 1'b0;
`endif
        if (op == 2'd0) return 4'h2;
        if (op == 2'd1) return 4'h6;
        if (op == 2'd2) begin
            if (f7 == 7'h00) return base_tab[f3];
            if (f7 == 7'h20) return (f3 == 3'd0) ? 4'h6 : (f3 == 3'd5) ? 4'h9 : 4'hF;
            if (f7 == 7'h01 && mext) begin
                if (f3 == 3'd0) return 4'hA;
                if (f3 == 3'd1) return 4'hB;
                if (f3 == 3'd4) return 4'hC;
                if (f3 == 3'd6) return 4'hD;
            end
            return 4'hF;
        end
        if (f3 == 3'd1) return (f7 == 7'h00) ? 4'h4 : 4'hF;
        if (f3 == 3'd5) return (f7 == 7'h00) ? 4'h5 : (f7 == 7'h20) ? 4'h9 : 4'hF;
        return base_tab[f3];
    endfunction

    function automatic int ref_busy_cycles(input logic [3:0] code);
        if (code == 4'hA || code == 4'hB) return MUL_LAT;
        if (code == 4'hC || code == 4'hD) return DIV_LAT;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] exp;
        int         nbusy;
        exp   = ref_code(op, f7, f3);
        nbusy = ref_busy_cycles(exp);
        bus.aluOp     = op;
        bus.Funct7    = f7;
        bus.Funct3    = f3;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        check("txn_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < nbusy; i++) begin
            check("busy_flag", 32'(bus.out_busy), 32'd1);
            check("busy_no_valid", 32'(bus.out_valid), 32'd0);
            check("busy_ctrl", 32'(bus.out_ctrl), 32'(exp));
            check("busy_not_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        check("res_valid", 32'(bus.out_valid), 32'd1);
        check("res_ctrl", 32'(bus.out_ctrl), 32'(exp));
        check("res_illegal", 32'(bus.out_illegal), 32'(exp == 4'hF));
        check("res_busy", 32'(bus.out_busy), 32'd0);
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] rop;
        logic [6:0] rf7;
        logic [2:0] rf3;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.aluOp     = 2'd0;
        bus.Funct7    = 7'd0;
        bus.Funct3    = 3'd0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.out_busy), 32'd0);
        check("rst_ctrl", 32'(bus.out_ctrl), 32'h2);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_illegal", 32'(bus.out_illegal), 32'd0);
        rst = 1'b0;

        // ADD then SUB back-to-back with no bubble
        bus.aluOp = 2'd2; bus.Funct7 = 7'h00; bus.Funct3 = 3'd0; bus.in_valid = 1'b1;
        tick();
        check("b2b_add_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_add_ctrl", 32'(bus.out_ctrl), 32'h2);
        check("b2b_ready", 32'(bus.in_ready), 32'd1);
        bus.Funct7 = 7'h20;
        tick();
        check("b2b_sub_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_sub_ctrl", 32'(bus.out_ctrl), 32'h6);
        bus.in_valid = 1'b0;
        tick();
        check("b2b_drain", 32'(bus.out_valid), 32'd0);

        txn(2'd3, 7'h20, 3'd5);
        txn(2'd3, 7'h00, 3'd5);
        txn(2'd3, 7'h01, 3'd5);
        txn(2'd0, 7'h7F, 3'd7);
        txn(2'd1, 7'h01, 3'd4);
        txn(2'd2, 7'h01, 3'd4);
        txn(2'd2, 7'h01, 3'd0);
        txn(2'd2, 7'h01, 3'd2);

        // stall: AND held while EX is not ready, a competing request must be ignored
        bus.out_ready = 1'b0;
        bus.aluOp = 2'd2; bus.Funct7 = 7'h00; bus.Funct3 = 3'd7; bus.in_valid = 1'b1;
        tick();
        bus.Funct7 = 7'h20; bus.Funct3 = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_ctrl", 32'(bus.out_ctrl), 32'h0);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("stall_release", 32'(bus.out_valid), 32'd0);
        check("stall_no_accept", 32'(bus.out_ctrl), 32'h0);

        // reset in the middle of a DIV window
        bus.aluOp = 2'd2; bus.Funct7 = 7'h01; bus.Funct3 = 3'd4; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(bus.out_busy), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_ctrl", 32'(bus.out_ctrl), 32'h2);
        rst = 1'b0;
        tick();

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            rf3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       rf7 = 7'h00;
                1:       rf7 = 7'h20;
                2:       rf7 = 7'h01;
                default: rf7 = 7'($urandom);
            endcase
            txn(rop, rf7, rf3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
